wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
Single owner of the register file's one write port. Merges three result sources into one registered write per cycle:
- ALU/pipeline writeback: fixed priority, no backpressure.
- LSU load returns: valid/ready handshake.
- Multi-cycle MUL/DIV results: valid/ready handshake.
Each side source has a one-entry holding register. The block also exports a pending-write mask for decode-stage hazard stalls and a starvation stall request.

Parameters:
XLEN, 32, data width of results and w_data
STARVE_LIMIT, 4, cycles a held entry may wait before stall_req asserts (range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result present this cycle; cannot be stalled
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  load result offered
lsu_ready  output  1  load result accepted when lsu_valid && lsu_ready
lsu_rd  input  5  load destination register
lsu_data  input  XLEN  load data
md_valid  input  1  MUL/DIV result offered
md_ready  output  1  MUL/DIV result accepted when md_valid && md_ready
md_rd  input  5  MUL/DIV destination register
md_data  input  XLEN  MUL/DIV result
RegWrite  output  1  register file write enable (registered)
w_reg_addr  output  32  write address, rd zero-extended (registered)
w_data  output  XLEN  write data (registered)
pending_mask  output  32  bit r = 1 while a held entry targets xr; bit 0 always 0
stall_req  output  1  request to upstream to insert one ALU bubble

Behaviour:
- Reset (synchronous, checked on clk rising edge):
  - RegWrite=0, w_reg_addr=0, w_data=0.
  - Both holds invalid; pending_mask=0; stall_req=0; wait counters=0.
  - Round-robin pointer favours LSU first.
- Reset wins over every simultaneous event. Entries held at reset are dropped.
- Hold registers (one per side source):
  - Capture rd/data on handshake.
  - Ready (combinational): lsu_ready = !lsu_hold_v || lsu_grant, same form for md. This allows one accept per cycle with back-to-back grants.
- Arbitration (combinational, each cycle), one grant at most:
  1. alu_valid=1: ALU granted; no side grant.
  2. Otherwise, exactly one hold valid: that hold granted.
  3. Otherwise, both holds valid: grant the source not granted last. The pointer updates only on a side grant.
- Output register:
  - On a grant with rd != 0, next edge sets RegWrite=1, w_reg_addr={27'b0,rd}, w_data=data.
  - Otherwise the next edge sets RegWrite=0; w_reg_addr/w_data hold their previous values.
  - rd=0 grants consume the entry but never assert RegWrite.
- Latency:
  - ALU: valid at cycle N gives RegWrite at N+1.
  - Side path: accept at N, held at N+1, RegWrite at N+2 at the earliest.
- pending_mask is derived from hold valid/rd state, so it changes one cycle after an accept or grant.
  - Both holds on the same rd: the bit stays set until both have drained.
- Starvation:
  - Each hold has a 4-bit wait counter. It increments each cycle the hold is valid but not granted, saturates at 15, and clears on grant or when the hold is empty.
  - stall_req = registered OR of (counter >= STARVE_LIMIT).
  - Upstream must drop alu_valid for at least one cycle after seeing stall_req=1.
- Ordering:
  - No ordering is guaranteed between sources; upstream is responsible for WAW hazards.
  - Within one source, writes retire in acceptance order.
- Simultaneous accept-and-grant on the same hold: the new entry replaces the granted one at the same edge, with no bubble.

Test Plan:
1. Reset: hold reset 2 cycles with all valids=1 -> RegWrite=0, w_reg_addr=0, w_data=0, pending_mask=0, lsu_ready=md_ready=1 after reset drops.
2. ALU priority: alu_valid rd=5 data=0x11 at N, lsu_valid rd=6 data=0x22 at N -> N+1 writes x5=0x11. N+2 writes x6=0x22 if ALU is idle at N+1. pending_mask bit 6 is 1 at N+1 and 0 at N+2.
3. Round robin: both holds valid (lsu x7=0xA, md x8=0xB), ALU idle -> write x7 first, then x8. Repeat -> next pair order is x8... only if LSU was granted last; verify alternation over 4 pairs.
4. x0 suppression: lsu rd=0 data=0xFFFF_FFFF accepted -> entry consumed, RegWrite stays 0, pending_mask stays 0.
5. Starvation: md hold valid, alu_valid=1 continuously, STARVE_LIMIT=4 -> stall_req=1 on 5th cycle after hold. Dropping alu_valid one cycle -> md write retires, stall_req returns to 0 next cycle.
6. Throughput/reset mid-op: lsu_valid=1 every cycle with ALU idle -> one write per cycle with ascending data. Assert reset mid-stream -> holds dropped, no write for dropped data after reset.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle: ALU writeback, LSU and MUL/DIV result
// channels in, registered write port, hazard mask and stall request out.
interface wb_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;

  logic            RegWrite;
  logic [31:0]     w_reg_addr;
  logic [XLEN-1:0] w_data;
  logic [31:0]     pending_mask;
  logic            stall_req;

  // Result producers and consumers of the write port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output md_valid, md_rd, md_data,
    input  lsu_ready, md_ready,
    input  RegWrite, w_reg_addr, w_data, pending_mask, stall_req
  );

  // The arbiter itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  md_valid, md_rd, md_data,
    output lsu_ready, md_ready,
    output RegWrite, w_reg_addr, w_data, pending_mask, stall_req
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter. The ALU result always wins the port; LSU
// and MUL/DIV results park in one-entry holds (stage p0) and are drained
// round-robin when the ALU is idle. The granted result is registered onto the
// write port (stage p1). Holds also feed a pending-write mask for decode
// hazard checks and a starvation stall request.
module wb_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  wb_write_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] WAIT_MAX = 4'hF;

  // Which side source wins when both holds are valid.
  typedef enum logic {
    RR_LSU = 1'b0,
    RR_MD  = 1'b1
  } rr_e;

  // Saturating wait counter step: cleared when empty or granted.
  function automatic logic [3:0] wait_step(input logic held, input logic granted,
                                           input logic [3:0] cnt);
    logic [3:0] nxt;
    if (!held || granted) begin
      nxt = 4'd0;
    end else if (cnt == WAIT_MAX) begin
      nxt = cnt;
    end else begin
      nxt = cnt + 4'd1;
    end
    return nxt;
  endfunction

  // One-hot pending bit for a held entry; x0 never shows as pending.
  function automatic logic [31:0] rd_bit(input logic held, input logic [4:0] rd);
    logic [31:0] m;
    m = 32'd0;
    if (held && (rd != 5'd0)) begin
      m[rd] = 1'b1;
    end
    return m;
  endfunction

  // ---- stage p0: side-source holding registers ----
  logic            lsu_vld_p0;
  logic [4:0]      lsu_rd_p0;
  logic [XLEN-1:0] lsu_data_p0;
  logic [3:0]      lsu_wait_p0;

  logic            md_vld_p0;
  logic [4:0]      md_rd_p0;
  logic [XLEN-1:0] md_data_p0;
  logic [3:0]      md_wait_p0;

  rr_e             rr_ptr;

  // ---- stage p1: registered write port ----
  logic            vld_p1;
  logic [31:0]     addr_p1;
  logic [XLEN-1:0] data_p1;
  logic            stall_p1;

  // Combinational arbitration and handshake terms.
  logic            lsu_grant;
  logic            md_grant;
  logic            lsu_accept;
  logic            md_accept;
  logic            any_grant;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [3:0]      lsu_wait_nxt;
  logic [3:0]      md_wait_nxt;

  // Grant selection: ALU first, then a lone hold, then round-robin.
  always_comb begin
    lsu_grant = 1'b0;
    md_grant  = 1'b0;
    if (!bus.alu_valid) begin
      if (lsu_vld_p0 && md_vld_p0) begin
        lsu_grant = (rr_ptr == RR_LSU);
        md_grant  = (rr_ptr == RR_MD);
      end else begin
        lsu_grant = lsu_vld_p0;
        md_grant  = md_vld_p0;
      end
    end
  end

  // A hold accepts when empty or when being drained this cycle.
  assign bus.lsu_ready = !lsu_vld_p0 || lsu_grant;
  assign bus.md_ready  = !md_vld_p0 || md_grant;
  assign lsu_accept    = bus.lsu_valid && bus.lsu_ready;
  assign md_accept     = bus.md_valid && bus.md_ready;

  // Mux the granted result toward the write port.
  always_comb begin
    any_grant = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = '0;
    if (bus.alu_valid) begin
      any_grant = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
    end else if (lsu_grant) begin
      any_grant = 1'b1;
      sel_rd    = lsu_rd_p0;
      sel_data  = lsu_data_p0;
    end else if (md_grant) begin
      any_grant = 1'b1;
      sel_rd    = md_rd_p0;
      sel_data  = md_data_p0;
    end
  end

  assign lsu_wait_nxt = wait_step(lsu_vld_p0, lsu_grant, lsu_wait_p0);
  assign md_wait_nxt  = wait_step(md_vld_p0, md_grant, md_wait_p0);

  // LSU hold: a new entry replaces a granted one with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_vld_p0  <= 1'b0;
      lsu_wait_p0 <= 4'd0;
    end else begin
      if (lsu_accept) begin
        lsu_vld_p0 <= 1'b1;
      end else if (lsu_grant) begin
        lsu_vld_p0 <= 1'b0;
      end
      lsu_wait_p0 <= lsu_wait_nxt;
    end
  end

  // LSU hold payload; qualified only by lsu_vld_p0.
  always_ff @(posedge clk) begin
    if (lsu_accept) begin
      lsu_rd_p0   <= bus.lsu_rd;
      lsu_data_p0 <= bus.lsu_data;
    end
  end

  // MUL/DIV hold: same behaviour as the LSU hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_vld_p0  <= 1'b0;
      md_wait_p0 <= 4'd0;
    end else begin
      if (md_accept) begin
        md_vld_p0 <= 1'b1;
      end else if (md_grant) begin
        md_vld_p0 <= 1'b0;
      end
      md_wait_p0 <= md_wait_nxt;
    end
  end

  // MUL/DIV hold payload; qualified only by md_vld_p0.
  always_ff @(posedge clk) begin
    if (md_accept) begin
      md_rd_p0   <= bus.md_rd;
      md_data_p0 <= bus.md_data;
    end
  end

  // Round-robin pointer: after a side grant, favour the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= RR_LSU;
    end else if (lsu_grant) begin
      rr_ptr <= RR_MD;
    end else if (md_grant) begin
      rr_ptr <= RR_LSU;
    end
  end

  // ---- stage p1: write port register; x0 grants retire silently ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= 32'd0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= any_grant && (sel_rd != 5'd0);
      if (any_grant && (sel_rd != 5'd0)) begin
        addr_p1 <= {27'd0, sel_rd};
        data_p1 <= sel_data;
      end
    end
  end

  // Stall request registered from the counters' next values, so it rises
  // in the same cycle the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_p1 <= 1'b0;
    end else begin
      stall_p1 <= (lsu_wait_nxt >= LIMIT) || (md_wait_nxt >= LIMIT);
    end
  end

  assign bus.RegWrite     = vld_p1;
  assign bus.w_reg_addr   = addr_p1;
  assign bus.w_data       = data_p1;
  assign bus.stall_req    = stall_p1;
  assign bus.pending_mask = rd_bit(lsu_vld_p0, lsu_rd_p0) | rd_bit(md_vld_p0, md_rd_p0);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, ALU priority, round-robin,
// shared-rd pending mask, x0 suppression, starvation and streaming/reset.
module tb_wb_write_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  wb_write_arbiter_if #(.XLEN(32)) bus();

  wb_write_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
    bus.md_valid  = 1'b0; bus.md_rd  = 5'd0; bus.md_data  = 32'd0;
  endtask

  logic [31:0] rr_addr [8];
  logic [31:0] rr_data [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    idle_inputs();

    // 1: reset with every source offering
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h44;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd5; bus.md_data  = 32'h55;
    tick();
    tick();
    check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("rst_addr", bus.w_reg_addr, 32'd0);
    check("rst_data", bus.w_data, 32'd0);
    check("rst_pending", bus.pending_mask, 32'd0);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("rst_md_ready", 32'(bus.md_ready), 32'd1);

    // 2: ALU beats a same-cycle LSU result
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h11;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h22;
    tick();
    check("alu_we", 32'(bus.RegWrite), 32'd1);
    check("alu_addr", bus.w_reg_addr, 32'd5);
    check("alu_data", bus.w_data, 32'h11);
    idle_inputs();
    #1;
    check("alu_pend_n1", bus.pending_mask, 32'h40);
    tick();
    check("lsu_we", 32'(bus.RegWrite), 32'd1);
    check("lsu_addr", bus.w_reg_addr, 32'd6);
    check("lsu_data", bus.w_data, 32'h22);
    check("lsu_pend_n2", bus.pending_mask, 32'd0);
    tick();
    check("idle_we", 32'(bus.RegWrite), 32'd0);
    check("idle_addr_hold", bus.w_reg_addr, 32'd6);
    check("idle_data_hold", bus.w_data, 32'h22);

    // 3: round-robin alternation over 4 pairs from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr_addr = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    rr_data = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3};
    begin
      int li, mi, wi;
      logic lacc, macc;
      li = 0; mi = 0; wi = 0;
      for (int c = 0; c < 14; c++) begin
        bus.lsu_valid = (li < 4);
        bus.lsu_rd    = 5'(7 + 2 * li);
        bus.lsu_data  = 32'hA0 + 32'(li);
        bus.md_valid  = (mi < 4);
        bus.md_rd     = 5'(8 + 2 * mi);
        bus.md_data   = 32'hB0 + 32'(mi);
        #1;
        lacc = bus.lsu_valid && bus.lsu_ready;
        macc = bus.md_valid && bus.md_ready;
        tick();
        if (lacc) li++;
        if (macc) mi++;
        if (bus.RegWrite) begin
          if (wi < 8) begin
            check("rr_addr", bus.w_reg_addr, rr_addr[wi]);
            check("rr_data", bus.w_data, rr_data[wi]);
          end else begin
            check("rr_extra_write", bus.w_reg_addr, 32'd0);
          end
          wi++;
        end
      end
      check("rr_write_count", 32'(wi), 32'd8);
    end
    idle_inputs();

    // 3b: both holds on x3; bit stays set until both drain (LSU favoured now)
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h31;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd3; bus.md_data  = 32'h32;
    tick();
    idle_inputs();
    #1;
    check("same_rd_pend0", bus.pending_mask, 32'h8);
    tick();
    check("same_rd_data1", bus.w_data, 32'h31);
    check("same_rd_pend1", bus.pending_mask, 32'h8);
    tick();
    check("same_rd_data2", bus.w_data, 32'h32);
    check("same_rd_addr2", bus.w_reg_addr, 32'd3);
    check("same_rd_pend2", bus.pending_mask, 32'd0);

    // 4: x0 load is consumed without a write
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    #1;
    check("x0_pend", bus.pending_mask, 32'd0);
    tick();
    check("x0_we", 32'(bus.RegWrite), 32'd0);
    check("x0_data_hold", bus.w_data, 32'h32);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    #1;
    check("x0_consumed_ready", 32'(bus.lsu_ready), 32'd1);
    tick();
    check("x0_alu_addr", bus.w_reg_addr, 32'd1);
    idle_inputs();

    // 5: starvation of an MD hold under continuous ALU traffic
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h55;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd9; bus.md_data  = 32'h99;
    tick();
    bus.md_valid = 1'b0;
    #1;
    check("starve_md_ready", 32'(bus.md_ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("starve_stall_c%0d", k), 32'(bus.stall_req), (k >= 5) ? 32'd1 : 32'd0);
      if (k < 5) tick();
    end
    bus.alu_valid = 1'b0;
    #1;
    check("starve_grant_ready", 32'(bus.md_ready), 32'd1);
    tick();
    check("starve_md_addr", bus.w_reg_addr, 32'd9);
    check("starve_md_data", bus.w_data, 32'h99);
    check("starve_stall_clear", 32'(bus.stall_req), 32'd0);
    idle_inputs();
    tick();

    // 6: one load per cycle, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'(i + 1);
      bus.lsu_data  = 32'h100 + 32'(i);
      tick();
      if (i >= 1) begin
        check($sformatf("stream_we_%0d", i), 32'(bus.RegWrite), 32'd1);
        check($sformatf("stream_data_%0d", i), bus.w_data, 32'h100 + 32'(i - 1));
      end
    end
    reset = 1'b1;
    bus.lsu_rd   = 5'd9;
    bus.lsu_data = 32'h108;
    tick();
    check("mid_rst_we", 32'(bus.RegWrite), 32'd0);
    check("mid_rst_data", bus.w_data, 32'd0);
    reset = 1'b0;
    idle_inputs();
    tick();
    check("post_rst_we1", 32'(bus.RegWrite), 32'd0);
    check("post_rst_pend", bus.pending_mask, 32'd0);
    tick();
    check("post_rst_we2", 32'(bus.RegWrite), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
